multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Control unit for the multicycle ARM datapath: a single shared memory port, instruction register (IR), PC, register file and one ALU, sequenced over several cycles per instruction. It decodes the IR contents, runs the main state machine, holds the NZCV flag register and evaluates condition codes. It replaces the single-cycle controller when the core is built in multicycle mode. All outputs except `PCWrite`, `RegWrite`, `MemWrite` and `IRWrite` are combinational functions of state, IR and the registered condition.

## Interface
- none (no parameters)

- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-low; state is reset on a rising edge that samples `reset` = 0
- `Instr`  in  20  IR bits [31:12]; stable from DECODE through the end of the instruction
- `ALUFlags`  in  4  {N,Z,C,V} from the ALU for the current cycle
- `IRWrite`  out  1  load IR from memory read data
- `AdrSrc`  out  1  memory address: 0 = PC, 1 = ALUOut
- `ALUSrcA`  out  2  00 = RD1 register, 01 = PC, 10 = ALUOut
- `ALUSrcB`  out  2  00 = RD2 (shifted), 01 = ExtImm, 10 = constant 4
- `ResultSrc`  out  2  00 = ALUOut, 01 = Data register, 10 = ALUResult
- `ImmSrc`  out  2  equal to `Instr[27:26]`
- `RegSrc`  out  2  [0] = (Op = 10), [1] = (Op = 01)
- `ShifterSrc`  out  1  1 when Op = 00 and `Instr[25]` = 0 (shifted-register operand)
- `ALUControl`  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR
- `PCWrite`  out  1  PC load enable
- `RegWrite`  out  1  register file write enable
- `MemWrite`  out  1  memory write enable
- `State`  out  4  current state encoding, for debug and the bench

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BRANCH 9. Encodings 10–15 are illegal and go to FETCH.
- Field names: Op = `Instr[27:26]`, Funct = `Instr[25:20]`, Rd = `Instr[15:12]`.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ALU ADD, ResultSrc=10, PCWrite=1. Next state DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=10, ALU ADD, ResultSrc=10 (PC+8 presented as R15). Latch CondExR.
  - Op=01 → MEMADR
  - Op=00 and Funct[5]=0 → EXECUTER
  - Op=00 and Funct[5]=1 → EXECUTEI
  - Op=10 → BRANCH
  - Op=11 → FETCH (no architectural effect)
- MEMADR: ALUSrcA=00, ALUSrcB=01, ALU ADD. Next state MEMREAD if Funct[0]=1, else MEMWRITE.
- MEMREAD: AdrSrc=1. Next state MEMWB.
- MEMWB: ResultSrc=01, RegW=1. Next state FETCH.
- MEMWRITE: AdrSrc=1, MemW=1. Next state FETCH.
- EXECUTER / EXECUTEI: ALUSrcA=00; ALUSrcB=00 (EXECUTER) or 01 (EXECUTEI). ALU operation comes from cmd = Funct[4:1]:
  - 0100 → ADD, 0010 → SUB, 0000 → AND, 1100 → ORR
  - any other cmd → ALUControl=00, and RegW is suppressed in the following ALUWB
  - Next state ALUWB.
- ALUWB: ResultSrc=00, RegW=1. Next state FETCH.
- BRANCH: ALUSrcA=00 (R15 via RegSrc), ALUSrcB=01, ALU ADD, ResultSrc=10, Branch=1. Next state FETCH.
- Condition logic:
  - CondEx is evaluated from `Instr[31:28]` against the flag register using the standard ARM table (EQ…AL); 1111 evaluates false.
  - CondExR is registered at the end of DECODE. All later states use only CondExR.
- Gated outputs:
  - RegWrite = RegW & CondExR
  - MemWrite = MemW & CondExR
  - PCWrite = (state FETCH) | (Branch & CondExR) | (RegW & CondExR & Rd=1111). The last term covers writes to R15 in ALUWB and MEMWB.
- Flag update: FlagW[1] = Funct[0] (S bit); FlagW[0] = S & cmd ∈ {ADD, SUB}.
  - At the end of EXECUTER/EXECUTEI, if CondExR=1: NZ ← ALUFlags[3:2] when FlagW[1]=1; CV ← ALUFlags[1:0] when FlagW[0]=1.
  - Flags are never written in any other state.

## Timing
- Reset (`reset`=0 at a clock edge): State=FETCH, flags=0000, CondExR=0.
- While `reset`=0, IRWrite, PCWrite, RegWrite and MemWrite are forced to 0.
- First FETCH takes effect on the first edge with `reset`=1.
- Reset asserted mid-instruction aborts it at that edge; no partial register or memory write occurs in the reset cycle.
- Instruction latencies in cycles: LDR 5, STR 4, DP 4, B 3, Op=11 2. Predicated-false instructions take the same cycle count, with no writes other than the FETCH PC+4.
- Flags written by instruction N are visible to instruction N+1, whose DECODE follows a later edge.
- Write enables are asserted for exactly one cycle per state visit.

## Test plan
- Reset then ADD R1,R2,#5 (E2821005), `ALUFlags`=0000: State sequence 0,1,7,8,0. RegWrite=1 only in ALUWB; ALUControl=00 in EXECUTEI.
- LDR R3,[R0,#8] (E5903008): states 0,1,2,3,4,0. AdrSrc=1 in MEMREAD; ResultSrc=01 and RegWrite=1 in MEMWB. STR (E5803008) visits MEMWRITE with MemWrite=1.
- SUBS R0,R0,R0 with `ALUFlags`=0100, then BEQ (0A000002): Z latched after EXECUTER; in BRANCH, PCWrite=1.
- Repeat the previous case with `ALUFlags`=0000 for SUBS: BNE-taken/BEQ-not-taken. In BRANCH, PCWrite=0; the state still returns to FETCH.
- ADD PC,R0,#0 (E280F000): PCWrite=1 and RegWrite=1 in ALUWB.
- Drive `reset`=0 during MEMWRITE: MemWrite=0 that cycle. Next State=FETCH and flags=0000.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: IR/flag inputs and datapath control outputs of the multicycle controller.
interface multicycle_controller_if;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        IRWrite;
    logic        AdrSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ResultSrc;
    logic [1:0]  ImmSrc;
    logic [1:0]  RegSrc;
    logic        ShifterSrc;
    logic [1:0]  ALUControl;
    logic        PCWrite;
    logic        RegWrite;
    logic        MemWrite;
    logic [3:0]  State;
    modport master (
        output Instr, ALUFlags,
        input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc,
        input  ShifterSrc, ALUControl, PCWrite, RegWrite, MemWrite, State
    );
    modport slave (
        input  Instr, ALUFlags,
        output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc,
        output ShifterSrc, ALUControl, PCWrite, RegWrite, MemWrite, State
    );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: main FSM, instruction decode, NZCV flags and condition check for the multicycle ARM datapath.
module multicycle_controller (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_controller_if.slave bus
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4,
        MEMWRITE = 4'd5, EXECUTER = 4'd6, EXECUTEI = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9
    } state_t;

    state_t     r_state;
    logic [3:0] r_flags;
    logic       r_cond_ex;

    logic [3:0] w_cond, w_cmd, w_rd;
    logic [1:0] w_op, w_alu_op;
    logic [5:0] w_funct;
    logic       w_n, w_z, w_c, w_v, w_cond_ex, w_cmd_ok, w_flag_cv;
    logic       w_fd, w_exec, w_reg_w, w_mem_w, w_branch, w_unused;

    assign w_cond    = bus.Instr[19:16];
    assign w_op      = bus.Instr[15:14];
    assign w_funct   = bus.Instr[13:8];
    assign w_rd      = bus.Instr[3:0];
    assign w_unused  = &{1'b0, bus.Instr[7:4]};
    assign w_cmd     = w_funct[4:1];
    assign {w_n, w_z, w_c, w_v} = r_flags;

    always_comb begin
        case (w_cond)
            4'b0000: w_cond_ex = w_z;
            4'b0001: w_cond_ex = !w_z;
            4'b0010: w_cond_ex = w_c;
            4'b0011: w_cond_ex = !w_c;
            4'b0100: w_cond_ex = w_n;
            4'b0101: w_cond_ex = !w_n;
            4'b0110: w_cond_ex = w_v;
            4'b0111: w_cond_ex = !w_v;
            4'b1000: w_cond_ex = w_c && !w_z;
            4'b1001: w_cond_ex = !w_c || w_z;
            4'b1010: w_cond_ex = w_n == w_v;
            4'b1011: w_cond_ex = w_n != w_v;
            4'b1100: w_cond_ex = !w_z && (w_n == w_v);
            4'b1101: w_cond_ex = w_z || (w_n != w_v);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    // Unsupported DP commands still execute as ADD but never write back
    assign w_cmd_ok  = w_cmd == 4'b0100 || w_cmd == 4'b0010 || w_cmd == 4'b0000 || w_cmd == 4'b1100;
    assign w_alu_op  = w_cmd == 4'b0010 ? 2'b01 : w_cmd == 4'b0000 ? 2'b10 : w_cmd == 4'b1100 ? 2'b11 : 2'b00;
    assign w_flag_cv = w_funct[0] && (w_cmd == 4'b0100 || w_cmd == 4'b0010);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= FETCH;
            r_flags   <= 4'b0000;
            r_cond_ex <= 1'b0;
        end else begin
            case (r_state)
                FETCH:    r_state <= DECODE;
                DECODE: begin
                    r_cond_ex <= w_cond_ex;
                    r_state   <= w_op == 2'b01 ? MEMADR : w_op == 2'b10 ? BRANCH :
                                 w_op == 2'b11 ? FETCH : w_funct[5] ? EXECUTEI : EXECUTER;
                end
                MEMADR:   r_state <= w_funct[0] ? MEMREAD : MEMWRITE;
                MEMREAD:  r_state <= MEMWB;
                EXECUTER, EXECUTEI: begin
                    if (r_cond_ex && w_funct[0]) r_flags[3:2] <= bus.ALUFlags[3:2];
                    if (r_cond_ex && w_flag_cv) r_flags[1:0] <= bus.ALUFlags[1:0];
                    r_state <= ALUWB;
                end
                default:  r_state <= FETCH;
            endcase
        end
    end

    assign w_fd     = r_state == FETCH || r_state == DECODE;
    assign w_exec   = r_state == EXECUTER || r_state == EXECUTEI;
    assign w_reg_w  = r_state == MEMWB || (r_state == ALUWB && w_cmd_ok);
    assign w_mem_w  = r_state == MEMWRITE;
    assign w_branch = r_state == BRANCH;

    assign bus.State      = r_state;
    assign bus.IRWrite    = reset && r_state == FETCH;
    assign bus.AdrSrc     = r_state == MEMREAD || r_state == MEMWRITE;
    assign bus.ALUSrcA    = w_fd ? 2'b01 : 2'b00;
    assign bus.ALUSrcB    = w_fd ? 2'b10 : (r_state == MEMADR || r_state == EXECUTEI || w_branch) ? 2'b01 : 2'b00;
    assign bus.ResultSrc  = (w_fd || w_branch) ? 2'b10 : r_state == MEMWB ? 2'b01 : 2'b00;
    assign bus.ALUControl = w_exec ? w_alu_op : 2'b00;
    assign bus.ImmSrc     = w_op;
    assign bus.RegSrc     = {w_op == 2'b01, w_op == 2'b10};
    assign bus.ShifterSrc = w_op == 2'b00 && !w_funct[5];
    assign bus.RegWrite   = reset && w_reg_w && r_cond_ex;
    assign bus.MemWrite   = reset && w_mem_w && r_cond_ex;
    assign bus.PCWrite    = reset && (r_state == FETCH || (w_branch && r_cond_ex) ||
                                      (w_reg_w && r_cond_ex && w_rd == 4'hF));
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: random instruction streams against an instruction-level model; a
// negedge monitor compares every cycle's control outputs with the expected record queue.
module tb_multicycle_controller;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    multicycle_controller_if bus();
    multicycle_controller dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct packed {
        logic [3:0] st;
        logic       irw, pcw, rw, mw, adr;
        logic [1:0] sa, sb, rs, alu, imm, rsrc;
        logic       shs;
    } exp_t;

    exp_t       q[$];
    exp_t       e, g;
    int         total = 0;
    int         bad = 0;
    logic [3:0] m_flags = 4'b0000;
    logic       m_cond = 1'b0;

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cc, v, b;
        {n, z, cc, v} = f;
        case (c[3:1])
            3'd0: b = z;
            3'd1: b = cc;
            3'd2: b = n;
            3'd3: b = v;
            3'd4: b = cc && !z;
            3'd5: b = n == v;
            3'd6: b = !z && (n == v);
            default: b = 1'b1;
        endcase
        return (c == 4'hF) ? 1'b0 : (c[0] ? !b : b);
    endfunction

    function automatic exp_t mk(input int s, input logic [31:0] ins, input logic rh, input logic cnd);
        exp_t       x;
        logic [1:0] op;
        logic [3:0] cmd;
        logic       legal, rwraw;
        op    = ins[27:26];
        cmd   = ins[24:21];
        legal = (cmd == 4'd4) || (cmd == 4'd2) || (cmd == 4'd0) || (cmd == 4'd12);
        x      = '0;
        x.st   = 4'(s);
        x.imm  = op;
        x.rsrc = {op == 2'd1, op == 2'd2};
        x.shs  = (op == 2'd0) && !ins[25];
        case (s)
            0: begin x.sa = 2'b01; x.sb = 2'b10; x.rs = 2'b10; end
            1: begin x.sa = 2'b01; x.sb = 2'b10; x.rs = 2'b10; end
            2: x.sb = 2'b01;
            3: x.adr = 1'b1;
            4: x.rs = 2'b01;
            5: x.adr = 1'b1;
            6: x.alu = cmd == 4'd2 ? 2'b01 : cmd == 4'd0 ? 2'b10 : cmd == 4'd12 ? 2'b11 : 2'b00;
            7: begin
                x.sb  = 2'b01;
                x.alu = cmd == 4'd2 ? 2'b01 : cmd == 4'd0 ? 2'b10 : cmd == 4'd12 ? 2'b11 : 2'b00;
            end
            9: begin x.sb = 2'b01; x.rs = 2'b10; end
            default: ;
        endcase
        rwraw = (s == 4) || (s == 8 && legal);
        x.irw = rh && s == 0;
        x.rw  = rh && rwraw && cnd;
        x.mw  = rh && s == 5 && cnd;
        x.pcw = rh && (s == 0 || (s == 9 && cnd) || (rwraw && cnd && ins[15:12] == 4'hF));
        return x;
    endfunction

    task automatic cyc(input int s, input logic [31:0] ins, input logic rh, input logic [3:0] af);
        @(posedge clk);
        #1;
        reset        = rh;
        bus.Instr    = ins[31:12];
        bus.ALUFlags = af;
        q.push_back(mk(s, ins, rh, m_cond));
    endtask

    task automatic run(input logic [31:0] ins, input int xf, input int abort_at);
        int         st[$];
        logic [3:0] af;
        logic       rh;
        logic [3:0] cmd;
        cmd = ins[24:21];
        case (ins[27:26])
            2'd0: st = '{0, 1, ins[25] ? 7 : 6, 8};
            2'd1: st = ins[20] ? '{0, 1, 2, 3, 4} : '{0, 1, 2, 5};
            2'd2: st = '{0, 1, 9};
            default: st = '{0, 1};
        endcase
        for (int k = 0; k < st.size(); k++) begin
            rh = (k != abort_at);
            af = ((st[k] == 6 || st[k] == 7) && xf >= 0) ? 4'(xf) : 4'($urandom_range(0, 15));
            cyc(st[k], ins, rh, af);
            if (!rh) begin
                m_flags = 4'b0000;
                m_cond  = 1'b0;
                return;
            end
            if (st[k] == 1) m_cond = cond_ok(ins[31:28], m_flags);
            if ((st[k] == 6 || st[k] == 7) && m_cond && ins[20]) begin
                m_flags[3:2] = af[3:2];
                if (cmd == 4'd4 || cmd == 4'd2) m_flags[1:0] = af[1:0];
            end
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            g = {bus.State, bus.IRWrite, bus.PCWrite, bus.RegWrite, bus.MemWrite, bus.AdrSrc,
                 bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUControl, bus.ImmSrc,
                 bus.RegSrc, bus.ShifterSrc};
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL cycle t=%0t state=%0d instr=%h: got %b want %b", $time, e.st, bus.Instr, g, e);
            end
        end
    end

    initial begin
        logic [31:0] ins;
        int          ab;
        bus.Instr    = '0;
        bus.ALUFlags = '0;
        repeat (2) @(posedge clk);
        cyc(0, 32'hE0000000, 1'b0, 4'b0000);
        run(32'hE2821005, 0, -1);
        run(32'hE5903008, -1, -1);
        run(32'hE5803008, -1, -1);
        run(32'hE0500000, 4, -1);
        run(32'h0A000002, -1, -1);
        run(32'hE0500000, 0, -1);
        run(32'h0A000002, -1, -1);
        run(32'h1A000002, -1, -1);
        run(32'hE280F000, -1, -1);
        run(32'hE0500000, 15, -1);
        run(32'hE5803008, -1, 3);
        run(32'h0A000002, -1, -1);
        run(32'hE591F000, -1, -1);
        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 2) != 0) ins[31:28] = 4'hE;
            ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1;
            run(ins, -1, ab);
        end
        repeat (3) @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
